// File: rtl/seq_wide_cmp_pkg.sv
// Shared types and helpers for the sequential wide comparator.
package seq_wide_cmp_pkg;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StRun  = 1'b1
  } state_e;

  // Chunk-index register width; kept at least one bit so a single-chunk build still elaborates.
  function automatic int unsigned idx_width(input int unsigned nchunk);
    return (nchunk > 1) ? $clog2(nchunk) : 1;
  endfunction

endpackage

// File: rtl/seq_cmp_chunk.sv
// Combinational CHUNK-bit compare. invert_msb turns the unsigned compare into a signed one.
module seq_cmp_chunk #(
  parameter int unsigned CHUNK = 16
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             invert_msb,
  output logic             eq,
  output logic             gt
);

  logic [CHUNK-1:0] flip;

  // Flipping both sign bits maps two's-complement order onto unsigned order.
  always_comb begin
    flip            = '0;
    flip[CHUNK-1]   = invert_msb;
  end

  assign eq = (x == y);
  assign gt = ((x ^ flip) > (y ^ flip));

endmodule

// File: rtl/seq_wide_cmp.sv
// Multi-cycle wide comparator: walks the operands MSB chunk first, one chunk per cycle.
module seq_wide_cmp
  import seq_wide_cmp_pkg::*;
#(
  parameter int unsigned WIDTH      = 64,
  parameter int unsigned CHUNK      = 16,
  parameter bit          EARLY_EXIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             flush,
  input  logic             op_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             equal,
  output logic             larger,
  output logic             less,
  output logic             gez,
  output logic             lez
);

  localparam int unsigned NCHUNK = (CHUNK == 0) ? 0 : WIDTH / CHUNK;
  localparam int unsigned IDX_W  = idx_width(NCHUNK);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  if ((CHUNK == 0) || (NCHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_param_err
    $error("seq_wide_cmp: WIDTH must be a non-zero multiple of CHUNK");
  end

  state_e           state_q;
  logic [IDX_W-1:0] idx_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             sgn_q, a_zero_q, a_neg_q;
  logic             diff_q, diff_gt_q;
  logic             done_q, equal_q, larger_q, less_q, gez_q, lez_q;

  logic [CHUNK-1:0] ch_x, ch_y;
  logic             ch_eq, ch_gt, invert_msb;
  logic             last, diff_any, diff_gt_sel, decide;

  // Select the current chunk of the captured operands (chunk 0 is the MSB chunk).
  always_comb begin
    ch_x = '0;
    ch_y = '0;
    for (int unsigned i = 0; i < NCHUNK; i++) begin
      if (idx_q == IDX_W'(i)) begin
        ch_x = a_q[WIDTH-1-i*CHUNK -: CHUNK];
        ch_y = b_q[WIDTH-1-i*CHUNK -: CHUNK];
      end
    end
  end

  assign invert_msb = sgn_q & (idx_q == '0);

  seq_cmp_chunk #(
    .CHUNK (CHUNK)
  ) u_chunk (
    .x          (ch_x),
    .y          (ch_y),
    .invert_msb (invert_msb),
    .eq         (ch_eq),
    .gt         (ch_gt)
  );

  // Decision terms: a difference latched on an earlier chunk wins over the current chunk.
  always_comb begin
    last        = (idx_q == LAST_IDX);
    diff_any    = diff_q | ~ch_eq;
    diff_gt_sel = diff_q ? diff_gt_q : ch_gt;
    decide      = (EARLY_EXIT && !ch_eq) || last;
  end

  // FSM, chunk counter, operand capture and registered results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      sgn_q     <= 1'b0;
      a_zero_q  <= 1'b0;
      a_neg_q   <= 1'b0;
      diff_q    <= 1'b0;
      diff_gt_q <= 1'b0;
      done_q    <= 1'b0;
      equal_q   <= 1'b0;
      larger_q  <= 1'b0;
      less_q    <= 1'b0;
      gez_q     <= 1'b0;
      lez_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start && !flush) begin
            state_q   <= StRun;
            idx_q     <= '0;
            a_q       <= a;
            b_q       <= b;
            sgn_q     <= op_signed;
            a_zero_q  <= ~|a;
            a_neg_q   <= op_signed & a[WIDTH-1];
            diff_q    <= 1'b0;
            diff_gt_q <= 1'b0;
          end
        end
        StRun: begin
          if (flush) begin
            // Abort: results keep their previous values, no done pulse.
            state_q <= StIdle;
          end else if (decide) begin
            state_q  <= StIdle;
            done_q   <= 1'b1;
            equal_q  <= ~diff_any;
            larger_q <= diff_any & diff_gt_sel;
            less_q   <= diff_any & ~diff_gt_sel;
            gez_q    <= ~a_neg_q;
            lez_q    <= a_neg_q | a_zero_q;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
            // Only reachable with a difference when early exit is off: remember the first one.
            if (!ch_eq && !diff_q) begin
              diff_q    <= 1'b1;
              diff_gt_q <= ch_gt;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy   = (state_q == StRun);
  assign done   = done_q;
  assign equal  = equal_q;
  assign larger = larger_q;
  assign less   = less_q;
  assign gez    = gez_q;
  assign lez    = lez_q;

endmodule

// File: tb/tb_seq_wide_cmp.sv
// Scoreboard bench for seq_wide_cmp: one early-exit instance, one full-latency instance.
module tb_seq_wide_cmp;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        start0 = 1'b0;
  logic        flush = 1'b0;
  logic        op_signed = 1'b0;
  logic [63:0] a = '0;
  logic [63:0] b = '0;

  logic busy, done, equal, larger, less, gez, lez;
  logic busy0, done0, equal0, larger0, less0, gez0, lez0;

  seq_wide_cmp #(
    .WIDTH      (64),
    .CHUNK      (16),
    .EARLY_EXIT (1'b1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .flush     (flush),
    .op_signed (op_signed),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .equal     (equal),
    .larger    (larger),
    .less      (less),
    .gez       (gez),
    .lez       (lez)
  );

  seq_wide_cmp #(
    .WIDTH      (64),
    .CHUNK      (16),
    .EARLY_EXIT (1'b0)
  ) dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start0),
    .flush     (flush),
    .op_signed (op_signed),
    .a         (a),
    .b         (b),
    .busy      (busy0),
    .done      (done0),
    .equal     (equal0),
    .larger    (larger0),
    .less      (less0),
    .gez       (gez0),
    .lez       (lez0)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // res = {equal, larger, less, gez, lez}; at = cycle count at which done is expected.
  typedef struct {
    logic [4:0] res;
    int         at;
  } exp_t;

  exp_t q1[$];
  exp_t q0[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitors: pop an expectation on every done pulse.
  always @(negedge clk) begin : mon1
    exp_t e;
    if (rst_n && done) begin
      if (q1.size() == 0) begin
        chk("ee1_unexpected_done", 64'd1, 64'd0);
      end else begin
        e = q1.pop_front();
        chk("ee1_results", {59'd0, equal, larger, less, gez, lez}, {59'd0, e.res});
        chk("ee1_latency", 64'(cyc), 64'(e.at));
      end
    end
  end

  always @(negedge clk) begin : mon0
    exp_t e;
    if (rst_n && done0) begin
      if (q0.size() == 0) begin
        chk("ee0_unexpected_done", 64'd1, 64'd0);
      end else begin
        e = q0.pop_front();
        chk("ee0_results", {59'd0, equal0, larger0, less0, gez0, lez0}, {59'd0, e.res});
        chk("ee0_latency", 64'(cyc), 64'(e.at));
      end
    end
  end

  task automatic wait_idle(input bit which);
    for (int i = 0; i < 20; i++) begin
      if (!(which ? busy0 : busy)) break;
      @(negedge clk);
    end
    chk("idle_timeout", {63'd0, (which ? busy0 : busy)}, 64'd0);
  endtask

  // Caller is at a negedge; returns in the done cycle.
  task automatic issue(input bit which, input logic [63:0] ta, input logic [63:0] tb2,
                       input logic sg, input int n, input logic [4:0] res);
    exp_t e;
    a         = ta;
    b         = tb2;
    op_signed = sg;
    e.res     = res;
    e.at      = cyc + 1 + n;
    if (which) begin
      start0 = 1'b1;
      q0.push_back(e);
    end else begin
      start = 1'b1;
      q1.push_back(e);
    end
    @(negedge clk);
    start  = 1'b0;
    start0 = 1'b0;
    chk("busy_after_accept", {63'd0, (which ? busy0 : busy)}, 64'd1);
    wait_idle(which);
  endtask

  int t0;

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_outputs", {57'd0, busy, done, equal, larger, less, gez, lez}, 64'd0);
    chk("reset_outputs0", {57'd0, busy0, done0, equal0, larger0, less0, gez0, lez0}, 64'd0);
    rst_n = 1'b1;

    @(negedge clk); issue(0, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 0, 4, 5'b10010);
    @(negedge clk); issue(0, 64'h8000_0000_0000_0000, 64'h1, 1, 1, 5'b00101);
    @(negedge clk); issue(0, 64'h8000_0000_0000_0000, 64'h1, 0, 1, 5'b01010);
    @(negedge clk); issue(0, 64'h0000_0005_0000_0000, 64'h0000_0003_FFFF_FFFF, 0, 2, 5'b01010);
    @(negedge clk); issue(1, 64'h0000_0005_0000_0000, 64'h0000_0003_FFFF_FFFF, 0, 4, 5'b01010);
    @(negedge clk); issue(1, 64'h8000_0000_0000_0000, 64'h1, 1, 4, 5'b00101);
    @(negedge clk); issue(0, 64'h0, 64'h0, 1, 4, 5'b10011);
    @(negedge clk); issue(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 1, 4, 5'b01001);

    // Run 1 equal with start held throughout; run 2 accepted in the done cycle, then flushed.
    @(negedge clk);
    a = 64'h0123_4567_89AB_CDEF;
    b = 64'h0123_4567_89AB_CDEF;
    op_signed = 1'b0;
    start = 1'b1;
    t0 = cyc;
    q1.push_back('{res: 5'b10010, at: t0 + 5});
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk("busy_hold_start", {63'd0, busy}, 64'd1);
    end
    @(negedge clk);
    chk("busy_in_done_cycle", {63'd0, busy}, 64'd0);
    a = 64'h5;
    b = 64'h3;
    @(negedge clk);
    start = 1'b0;
    chk("accept_in_done_cycle", {63'd0, busy}, 64'd1);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("busy_after_flush", {63'd0, busy}, 64'd0);
    chk("equal_kept_after_flush", {61'd0, equal, larger, less}, 64'b100);
    repeat (6) @(negedge clk);
    chk("still_idle_after_flush", {63'd0, busy}, 64'd0);

    // Asynchronous reset between edges while running.
    @(negedge clk);
    a = 64'h0;
    b = 64'h0;
    op_signed = 1'b0;
    start = 1'b1;
    start0 = 1'b1;
    @(negedge clk);
    start = 1'b0;
    start0 = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", {57'd0, busy, done, equal, larger, less, gez, lez}, 64'd0);
    chk("async_reset_outputs0", {57'd0, busy0, done0, equal0, larger0, less0, gez0, lez0}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); issue(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 1, 4, 5'b01001);

    repeat (5) @(negedge clk);
    chk("queue_drained_ee1", 64'(q1.size()), 64'd0);
    chk("queue_drained_ee0", 64'(q0.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
